// File: rtl/membus_avl_bridge.sv
// ---------------------------------------------------------------------------
// membus_avl_bridge : PDP-6 membus cycle -> Avalon-MM read/write serialiser
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module membus_avl_bridge #(
  parameter int AW = 18,
  parameter int DW = 36
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_rq_cyc,
  input  logic          i_rd_rq,
  input  logic          i_wr_rq,
  input  logic [AW-1:0] i_ma,
  input  logic [DW-1:0] i_mb_write,
  input  logic          i_wr_rs,
  output logic          o_addr_ack,
  output logic          o_rd_rs,
  output logic [DW-1:0] o_mb_read,
  output logic [AW-1:0] o_address,
  output logic          o_read,
  output logic          o_write,
  output logic [DW-1:0] o_writedata,
  input  logic [DW-1:0] i_readdata,
  input  logic          i_waitrequest
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    RD    = 3'd2,
    RDRS  = 3'd3,
    WWAIT = 3'd4,
    WR    = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t state, state_nx;
  logic   rd_flag, wr_flag;

  // Once RD or WR is entered the Avalon transfer always runs to completion,
  // regardless of i_rq_cyc; only WWAIT and DONE look at the cycle request.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_rq_cyc && (i_rd_rq || i_wr_rq)) state_nx = ACK;
      ACK:     state_nx = rd_flag ? RD : WWAIT;
      RD:      if (!i_waitrequest) state_nx = RDRS;
      RDRS:    state_nx = wr_flag ? WWAIT : DONE;
      WWAIT: begin
        if (i_wr_rs)        state_nx = WR;
        else if (!i_rq_cyc) state_nx = IDLE;
      end
      WR:      if (!i_waitrequest) state_nx = DONE;
      DONE:    if (!i_rq_cyc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      rd_flag     <= 1'b0;
      wr_flag     <= 1'b0;
      o_addr_ack  <= 1'b0;
      o_rd_rs     <= 1'b0;
      o_read      <= 1'b0;
      o_write     <= 1'b0;
      o_address   <= '0;
      o_mb_read   <= '0;
      o_writedata <= '0;
    end else begin
      state      <= state_nx;
      o_addr_ack <= (state_nx == ACK);
      o_read     <= (state_nx == RD);
      o_rd_rs    <= (state_nx == RDRS);
      o_write    <= (state_nx == WR);
      if (state == IDLE && state_nx == ACK) begin
        o_address <= i_ma;
        rd_flag   <= i_rd_rq;
        wr_flag   <= i_wr_rq;
      end
      if (state == RD && !i_waitrequest)
        o_mb_read <= i_readdata;
      if (state == WWAIT && i_wr_rs)
        o_writedata <= i_mb_write;
    end
  end

endmodule

`default_nettype wire
